// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: 4x4 matrix keypad front end.
// Drives one-hot columns, synchronizes the row inputs, and debounces both press
// and release. Emits exactly one key_valid pulse per accepted physical press.
// Ports:
//   clk       - system clock
//   rst_in    - asynchronous active-low reset
//   fil[3:0]  - keypad rows, active-high, asynchronous to clk
//   col[3:0]  - one-hot column drive
//   key_code  - code of the last accepted key, held until the next one
//   key_valid - one-cycle pulse on key acceptance
//   key_held  - high from acceptance until the release is debounced
module keypad_scan_debounce #(
  parameter int unsigned SCAN_CYCLES     = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_in,
  input  logic [3:0] fil,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned MAX_CYC = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       sync1_q, fs_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       col_q, col_d, col_next;
  logic [3:0]       pat_q, pat_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             fs_onehot;

  // Index of the set bit in a one-hot nibble.
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    case (v)
      4'b0010: onehot_idx = 2'd1;
      4'b0100: onehot_idx = 2'd2;
      4'b1000: onehot_idx = 2'd3;
      default: onehot_idx = 2'd0;
    endcase
  endfunction

  // Keypad legend: row-major {row, col} to key code.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] c);
    case ({row, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  default: key_map = 4'hD;
    endcase
  endfunction

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      sync1_q <= 4'd0;
      fs_q    <= 4'd0;
    end else begin
      sync1_q <= fil;
      fs_q    <= sync1_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_SCAN;
      cnt_q       <= '0;
      col_q       <= 4'b0001;
      pat_q       <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      pat_q       <= pat_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // Next-state logic; one counter serves scan window, press and release debounce.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    pat_d       = pat_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    fs_onehot = (fs_q != 4'd0) && ((fs_q & (fs_q - 4'd1)) == 4'd0);
    col_next  = {col_q[2:0], col_q[3]};
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      ST_SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (fs_onehot) begin
            pat_d   = fs_q;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = col_next;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DEBOUNCE: begin
        if (fs_q != pat_q) begin
          state_d = ST_SCAN;
          col_d   = col_next;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          key_code_d  = key_map(onehot_idx(pat_q), onehot_idx(col_q));
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = ST_HELD;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HELD: begin
        // Any activity restarts the release count, so bounce or a second key is ignored.
        if (fs_q != 4'd0) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          key_held_d = 1'b0;
          state_d    = ST_SCAN;
          col_d      = col_next;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
